// File: rtl/vend_credit_ctrl.sv
// Vending credit controller: accumulates coins, vends against a packed price table, and
// returns change one unit per valid/ready handshake. Optional refund input: VEND_CANCEL_EN.
module vend_credit_ctrl #(
  parameter int unsigned                    CREDIT_W   = 4,
  parameter int unsigned                    N_PRODUCTS = 4,
  parameter int unsigned                    SEL_W      = 3,
  parameter logic [N_PRODUCTS*CREDIT_W-1:0] PRICES     = 16'h7541
) (
  input  logic                clk,
  input  logic                rst_n,
`ifdef VEND_CANCEL_EN
  input  logic                cancel,
`endif
  input  logic                coin_valid,
  input  logic [CREDIT_W-1:0] coin_value,
  output logic                coin_ready,
  output logic                coin_reject,
  input  logic [SEL_W-1:0]    sel,
  input  logic                buy,
  output logic                enough,
  output logic                insufficient,
  output logic                dispense,
  output logic [SEL_W-1:0]    product_id,
  output logic                change_valid,
  input  logic                change_ready,
  output logic [CREDIT_W-1:0] credit,
  output logic                busy
);

  typedef enum logic [1:0] {StIdle, StCredit, StVend, StChange} state_e;

  state_e              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [SEL_W-1:0]    product_id_q, product_id_d;
  logic                coin_reject_q, coin_reject_d;
  logic                insufficient_q, insufficient_d;
  logic                dispense_q, dispense_d;

  logic [CREDIT_W-1:0] price;
  logic                sel_ok;
  logic                accepting;
  logic                cancel_hit;
  logic [CREDIT_W:0]   coin_sum;

  // Selections outside 1..N_PRODUCTS leave sel_ok low and price zero.
  always_comb begin
    price  = '0;
    sel_ok = 1'b0;
    for (int unsigned k = 0; k < N_PRODUCTS; k++) begin
      if (sel == SEL_W'(k + 1)) begin
        price  = PRICES[k*CREDIT_W +: CREDIT_W];
        sel_ok = 1'b1;
      end
    end
  end

`ifdef VEND_CANCEL_EN
  assign cancel_hit = cancel && (state_q == StCredit);
`else
  assign cancel_hit = 1'b0;
`endif

  assign accepting  = (state_q == StIdle) || (state_q == StCredit);
  assign enough     = sel_ok && (price != '0) && (credit_q >= price);
  assign coin_ready = accepting && !buy && !cancel_hit;
  // One extra bit so an overflowing coin is detected rather than wrapped.
  assign coin_sum   = {1'b0, credit_q} + {1'b0, coin_value};

  always_comb begin
    state_d        = state_q;
    credit_d       = credit_q;
    product_id_d   = product_id_q;
    coin_reject_d  = 1'b0;
    insufficient_d = 1'b0;
    dispense_d     = 1'b0;
    unique case (state_q)
      StIdle, StCredit: begin
        if (cancel_hit) begin
          state_d = StChange;
        end else if (buy) begin
          if (enough) begin
            credit_d     = credit_q - price;
            product_id_d = sel;
            dispense_d   = 1'b1;
            state_d      = StVend;
          end else begin
            insufficient_d = 1'b1;
          end
        end else if (coin_valid) begin
          if (coin_sum[CREDIT_W]) begin
            coin_reject_d = 1'b1;
          end else begin
            credit_d = coin_sum[CREDIT_W-1:0];
            if (coin_sum[CREDIT_W-1:0] != '0) state_d = StCredit;
          end
        end
      end
      StVend: begin
        state_d = (credit_q != '0) ? StChange : StIdle;
      end
      StChange: begin
        if (credit_q == '0) begin
          state_d = StIdle;
        end else if (change_ready) begin
          credit_d = credit_q - CREDIT_W'(1);
          if (credit_q == CREDIT_W'(1)) state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      credit_q       <= '0;
      product_id_q   <= '0;
      coin_reject_q  <= 1'b0;
      insufficient_q <= 1'b0;
      dispense_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      credit_q       <= credit_d;
      product_id_q   <= product_id_d;
      coin_reject_q  <= coin_reject_d;
      insufficient_q <= insufficient_d;
      dispense_q     <= dispense_d;
    end
  end

  assign credit       = credit_q;
  assign product_id   = product_id_q;
  assign coin_reject  = coin_reject_q;
  assign insufficient = insufficient_q;
  assign dispense     = dispense_q;
  assign busy         = (state_q == StVend) || (state_q == StChange);
  assign change_valid = (state_q == StChange) && (credit_q != '0);

endmodule

// File: tb/tb_vend_credit_ctrl.sv
// Bench for vend_credit_ctrl: directed scenarios plus random traffic, checked against a
// behavioural credit/refund model. Exercises the cancel input when VEND_CANCEL_EN is defined.
module tb_vend_credit_ctrl;
  localparam int unsigned CW  = 4;
  localparam int unsigned SW  = 3;
  localparam int          MAX = (1 << CW) - 1;
`ifdef VEND_CANCEL_EN
  localparam bit CancelEn = 1'b1;
`else
  localparam bit CancelEn = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cancel = 1'b0;
  logic          coin_valid = 1'b0;
  logic [CW-1:0] coin_value = '0;
  logic          coin_ready;
  logic          coin_reject;
  logic [SW-1:0] sel = '0;
  logic          buy = 1'b0;
  logic          enough;
  logic          insufficient;
  logic          dispense;
  logic [SW-1:0] product_id;
  logic          change_valid;
  logic          change_ready = 1'b0;
  logic [CW-1:0] credit;
  logic          busy;

  vend_credit_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
`ifdef VEND_CANCEL_EN
    .cancel       (cancel),
`endif
    .coin_valid   (coin_valid),
    .coin_value   (coin_value),
    .coin_ready   (coin_ready),
    .coin_reject  (coin_reject),
    .sel          (sel),
    .buy          (buy),
    .enough       (enough),
    .insufficient (insufficient),
    .dispense     (dispense),
    .product_id   (product_id),
    .change_valid (change_valid),
    .change_ready (change_ready),
    .credit       (credit),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Model: credit as an integer, plus "a vend is happening" and "refund in progress" flags.
  int m_credit = 0;
  bit m_vend   = 1'b0;
  bit m_refund = 1'b0;
  int e_pid    = 0;
  bit e_disp   = 1'b0;
  bit e_rej    = 1'b0;
  bit e_ins    = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
  endtask

  function automatic int price_of(input int s);
    int p[5] = '{0, 1, 4, 5, 7};
    if (s >= 1 && s <= 4) return p[s];
    return 0;
  endfunction

  task automatic model_reset();
    m_credit = 0; m_vend = 1'b0; m_refund = 1'b0;
    e_pid = 0; e_disp = 1'b0; e_rej = 1'b0; e_ins = 1'b0;
  endtask

  task automatic model_step(input bit cv, input int cval, input int s, input bit b,
                            input bit cr, input bit cn);
    int p;
    e_disp = 1'b0; e_rej = 1'b0; e_ins = 1'b0;
    if (m_vend) begin
      m_vend   = 1'b0;
      m_refund = (m_credit > 0);
    end else if (m_refund) begin
      if (cr) begin
        m_credit--;
        if (m_credit == 0) m_refund = 1'b0;
      end
    end else if (CancelEn && cn && m_credit > 0) begin
      m_refund = 1'b1;
    end else if (b) begin
      p = price_of(s);
      if (p != 0 && m_credit >= p) begin
        m_credit -= p; m_vend = 1'b1; e_disp = 1'b1; e_pid = s;
      end else begin
        e_ins = 1'b1;
      end
    end else if (cv) begin
      if (m_credit + cval > MAX) e_rej = 1'b1;
      else m_credit += cval;
    end
  endtask

  task automatic check_outputs();
    check_val("credit", 32'(credit), 32'(m_credit));
    check_val("dispense", 32'(dispense), 32'(e_disp));
    if (e_disp) check_val("product_id", 32'(product_id), 32'(e_pid));
    check_val("change_valid", 32'(change_valid), 32'(m_refund));
    check_val("busy", 32'(busy), 32'(m_vend || m_refund));
    check_val("coin_reject", 32'(coin_reject), 32'(e_rej));
    check_val("insufficient", 32'(insufficient), 32'(e_ins));
  endtask

  // Called one time unit after a rising edge; returns at the same phase of the next cycle.
  task automatic cycle(input bit cv, input int cval, input int s, input bit b,
                       input bit cr, input bit cn);
    bit idle;
    int p;
    coin_valid = cv; coin_value = CW'(cval); sel = SW'(s); buy = b;
    change_ready = cr; cancel = cn;
    #1;
    idle = !m_vend && !m_refund;
    p = price_of(s);
    check_val("enough", 32'(enough), 32'(p != 0 && m_credit >= p));
    check_val("coin_ready", 32'(coin_ready),
              32'(idle && !b && !(CancelEn && cn && m_credit > 0)));
    model_step(cv, cval, s, b, cr, cn);
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic do_reset();
    coin_valid = 1'b0; buy = 1'b0; change_ready = 1'b0; cancel = 1'b0; sel = '0;
    #1 rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    check_val("rst_product_id", 32'(product_id), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish (got timeout, expected completion)");
    $fatal(1, "watchdog expired");
  end

  initial begin
    @(posedge clk);
    #1;
    do_reset();

    // Coins 2 and 3, then price checks for sel 3 and 4.
    cycle(1, 2, 0, 0, 0, 0);
    cycle(1, 3, 0, 0, 0, 0);
    cycle(0, 0, 3, 0, 0, 0);
    cycle(0, 0, 4, 0, 0, 0);
    // Buy product 2, then one change unit.
    cycle(0, 0, 2, 1, 0, 0);
    cycle(0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 1, 0);
    cycle(0, 0, 0, 0, 0, 0);
    // Credit 5, product 4 refused.
    cycle(1, 5, 0, 0, 0, 0);
    cycle(0, 0, 4, 1, 0, 0);
    cycle(0, 0, 0, 0, 0, 0);
    // Zero coin, buy-vs-coin collision, up to 14, overflow reject, then max.
    cycle(1, 0, 0, 0, 0, 0);
    cycle(1, 4, 7, 1, 0, 0);
    cycle(1, 4, 0, 0, 0, 0);
    cycle(1, 5, 0, 0, 0, 0);
    cycle(1, 3, 0, 0, 0, 0);
    cycle(1, 1, 0, 0, 0, 0);
    cycle(1, 1, 0, 0, 0, 0);
    // Drain: buy product 4 from 15, then hand back 8 units.
    cycle(0, 0, 4, 1, 0, 0);
    for (int i = 0; i < 10; i++) cycle(1, 2, 1, 1, 1, 0);
    // Credit 7, buy product 1, stall 5 cycles, 3 handshakes, then reset mid-change.
    cycle(1, 7, 0, 0, 0, 0);
    cycle(0, 0, 1, 1, 0, 0);
    for (int i = 0; i < 6; i++) cycle(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 1, 0);
    do_reset();
    // Cancel together with buy and coin from credit 4.
    cycle(1, 4, 0, 0, 0, 0);
    cycle(1, 2, 1, 1, 0, 1);
    for (int i = 0; i < 6; i++) cycle(0, 0, 0, 0, 1, 0);
    cycle(1, 3, 0, 0, 0, 1);

    for (int i = 0; i < 600; i++) begin
      bit cv, b, cr, cn;
      int cval, s;
      cv   = ($urandom_range(0, 9) < 5);
      cval = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, MAX))
                                         : int'($urandom_range(0, 5));
      s    = int'($urandom_range(0, 7));
      b    = ($urandom_range(0, 9) < 2);
      cr   = ($urandom_range(0, 9) < 6);
      cn   = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 249) == 0) do_reset();
      else cycle(cv, cval, s, b, cr, cn);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
